posi_md_rd_ctrl: RTL

- Downstream consumer of the intra-mode ping-pong buffer that the pre-intra (prei) stage fills.
- On a start pulse it sweeps every mode entry of one CU size for the current CTU, in z-order.
- It drives the buffer's read port (posi_md_ena/addr, 1-cycle read latency) and returns the modes as a valid/ready stream to the position-intra stage.
- It absorbs the read latency under backpressure with a 2-entry skid FIFO.

---
 rtl/posi_md_rd_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/posi_md_rd_ctrl.sv
// Intra-mode buffer reader: sweeps one CU size in z-order and streams the
// modes downstream, absorbing the 1-cycle read latency in a 2-entry skid FIFO.
module posi_md_rd_ctrl #(
    parameter int MD_W  = 6,
    parameter int ADR_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       size_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             posi_md_ena_o,
    output logic [ADR_W-1:0] posi_md_addr_o,
    input  logic [MD_W-1:0]  posi_md_data_i,
    output logic             md_valid_o,
    input  logic             md_ready_i,
    output logic [MD_W-1:0]  md_o,
    output logic [7:0]       md_idx_o,
    output logic             md_last_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic [1:0]            r_size;
    logic [8:0]            r_rd_cnt;
    logic [8:0]            r_out_cnt;
    logic                  r_inflight;
    logic [7:0]            r_in_idx;
    logic [1:0][MD_W-1:0]  r_fifo_md;
    logic [1:0][7:0]       r_fifo_idx;
    logic                  r_wp;
    logic                  r_rp;
    logic [1:0]            r_fcnt;

    logic [ADR_W-1:0]      w_base;
    logic [8:0]            w_count;
    logic                  w_empty;
    logic                  w_valid;
    logic [MD_W-1:0]       w_head_md;
    logic [7:0]            w_head_idx;
    logic                  w_pop;
    logic                  w_fpop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_last;
    logic                  w_done;

    always_comb begin
        w_base  = '0;
        w_count = '0;
        unique case (r_size)
            2'd3: begin w_base = ADR_W'(0);  w_count = 9'd4;   end
            2'd2: begin w_base = ADR_W'(4);  w_count = 9'd16;  end
            2'd1: begin w_base = ADR_W'(20); w_count = 9'd64;  end
            2'd0: begin w_base = ADR_W'(84); w_count = 9'd256; end
        endcase
    end

    // An in-flight read is presented directly when the FIFO is empty,
    // so data reaches the consumer in the same cycle it leaves the buffer.
    assign w_empty    = (r_fcnt == 2'd0);
    assign w_valid    = !w_empty || r_inflight;
    assign w_head_md  = w_empty ? posi_md_data_i : r_fifo_md[r_rp];
    assign w_head_idx = w_empty ? r_in_idx : r_fifo_idx[r_rp];
    assign w_pop      = w_valid && md_ready_i;
    assign w_fpop     = !w_empty && w_pop;
    assign w_push     = r_inflight && !(w_empty && w_pop);
    assign w_issue    = (r_state == S_RUN) && (r_rd_cnt < w_count) &&
                        ((r_fcnt + {1'b0, r_inflight}) < 2'd2);
    assign w_last     = w_valid && ({1'b0, w_head_idx} == (w_count - 9'd1));
    assign w_done     = w_pop && (r_out_cnt == (w_count - 9'd1));

    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = w_done;
    assign posi_md_ena_o  = w_issue;
    assign posi_md_addr_o = w_issue ? (w_base + ADR_W'(r_rd_cnt)) : '0;
    assign md_valid_o     = w_valid;
    assign md_o           = w_valid ? w_head_md : '0;
    assign md_idx_o       = w_valid ? w_head_idx : '0;
    assign md_last_o      = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_size     <= '0;
            r_rd_cnt   <= '0;
            r_out_cnt  <= '0;
            r_inflight <= 1'b0;
            r_in_idx   <= '0;
            r_fifo_md  <= '0;
            r_fifo_idx <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_fcnt     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_in_idx <= r_rd_cnt[7:0];
                r_rd_cnt <= r_rd_cnt + 9'd1;
            end
            if (w_push) begin
                r_fifo_md[r_wp]  <= posi_md_data_i;
                r_fifo_idx[r_wp] <= r_in_idx;
                r_wp             <= ~r_wp;
            end
            if (w_fpop) begin
                r_rp <= ~r_rp;
            end
            case ({w_push, w_fpop})
                2'b10:   r_fcnt <= r_fcnt + 2'd1;
                2'b01:   r_fcnt <= r_fcnt - 2'd1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 9'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_size    <= size_i;
                        r_rd_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end else if (r_rd_cnt == w_count) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
